// File: rtl/divider_256by128_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (accept on in_valid & in_ready)
//   dividend [2*WIDTH]     numerator, latched at acceptance
//   divisor  [WIDTH]       denominator, latched at acceptance
//   out_valid / out_ready  result handshake (results held under backpressure)
//   quotient  [WIDTH]      floor(dividend/divisor), all ones on overflow
//   remainder [WIDTH]      dividend mod divisor, zero on overflow
//   ovf                    quotient does not fit WIDTH bits, or divisor == 0
//
// Build option:
//   DIV_FAST_OVF_EN  when defined, an overflowing operation bypasses the
//                    iteration and reports one cycle after acceptance.
module divider_256by128_seq #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state,     w_state_nxt;
  logic [WIDTH:0]     r_rem,       w_rem_nxt;
  logic [WIDTH-1:0]   r_q,         w_q_nxt;
  logic [WIDTH-1:0]   r_div,       w_div_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic               r_ovf_det,   w_ovf_det_nxt;
  logic               r_in_ready,  w_in_ready_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0]   r_quot,      w_quot_nxt;
  logic [WIDTH-1:0]   r_remo,      w_remo_nxt;
  logic               r_ovf,       w_ovf_nxt;

  logic               w_ovf_in;
  logic [WIDTH+1:0]   w_diff;
  logic               w_neg;

  // High half not below the divisor means the quotient needs more than WIDTH
  // bits; divisor == 0 falls out of the same compare.
  assign w_ovf_in = dividend[2*WIDTH-1:WIDTH] >= divisor;

  // Trial subtraction on the shifted partial remainder; one extra bit holds the sign.
  assign w_diff = {1'b0, r_rem[WIDTH-1:0], r_q[WIDTH-1]} - {2'b00, r_div};
  assign w_neg  = w_diff[WIDTH+1];

  // Next-state, datapath and output-register logic
  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_q_nxt         = r_q;
    w_div_nxt       = r_div;
    w_cnt_nxt       = r_cnt;
    w_ovf_det_nxt   = r_ovf_det;
    w_out_valid_nxt = r_out_valid;
    w_quot_nxt      = r_quot;
    w_remo_nxt      = r_remo;
    w_ovf_nxt       = r_ovf;

    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_rem_nxt     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
          w_q_nxt       = dividend[WIDTH-1:0];
          w_div_nxt     = divisor;
          w_cnt_nxt     = CNT_W'(WIDTH);
          w_ovf_det_nxt = w_ovf_in;
          w_state_nxt   = CALC;
`ifdef DIV_FAST_OVF_EN
          if (w_ovf_in) begin
            w_cnt_nxt   = '0;
            w_state_nxt = DONE;
          end
`endif
        end
      end
      CALC: begin
        w_rem_nxt = w_neg ? {r_rem[WIDTH-1:0], r_q[WIDTH-1]} : w_diff[WIDTH:0];
        w_q_nxt   = {r_q[WIDTH-2:0], ~w_neg};
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (!r_out_valid) begin
          // First DONE cycle: capture the result once, then hold it.
          // r_rem[WIDTH] is a guard bit that only an out-of-range run can set.
          w_out_valid_nxt = 1'b1;
          w_ovf_nxt       = r_ovf_det | r_rem[WIDTH];
          w_quot_nxt      = w_ovf_nxt ? '1 : r_q;
          w_remo_nxt      = w_ovf_nxt ? '0 : r_rem[WIDTH-1:0];
        end else if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_in_ready_nxt = (w_state_nxt == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_ovf_det   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_remo      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_q         <= w_q_nxt;
      r_div       <= w_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf_det   <= w_ovf_det_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_quot      <= w_quot_nxt;
      r_remo      <= w_remo_nxt;
      r_ovf       <= w_ovf_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_divider_256by128_seq.sv
// Scoreboard bench for divider_256by128_seq: the driver pushes hand-computed
// expectations on acceptance, the monitor pops and checks on each output handshake.
module tb_divider_256by128_seq;

  localparam int unsigned W = 128;
`ifdef DIV_FAST_OVF_EN
  localparam int OVF_LAT = 1;
`else
  localparam int OVF_LAT = W + 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;

  divider_256by128_seq #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         o;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: samples at negedge, where values equal those seen by the next posedge.
  initial begin : monitor
    bit   seen;
    int   rise;
    exp_t e;
    seen = 1'b0;
    rise = 0;
    forever begin
      @(negedge clk);
      if (!out_valid) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          rise = cyc;
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output actual=out_valid required=no_result_pending");
          end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("ovf", W'(ovf), W'(e.o));
            chk("latency", W'(rise - e.acc), W'(e.lat));
          end
        end
      end
    end
  end

  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic eo);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 400);
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      e.q   = eq;
      e.r   = er;
      e.o   = eo;
      e.acc = cyc + 1;
      e.lat = eo ? OVF_LAT : int'(W + 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = ~dd;
    divisor  = ~dv;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : driver
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_ovf", W'(ovf), W'(0));
    rst_n = 1'b1;

    // Product recovery, then remainder carried through, then overflow cases.
    issue(256'h3489BE8E_CB764171_00000000, 128'hFFFFFFFF, 128'h3489BE8F_00000000, 128'd0, 1'b0);
    issue(256'h3489BE8E_CB764171_00000005, 128'hFFFFFFFF, 128'h3489BE8F_00000000, 128'd5, 1'b0);
    issue(256'h123BBBCF_00000000, 128'd0, '1, 128'd0, 1'b1);
    issue({128'd1, 128'd0}, 128'd1, '1, 128'd0, 1'b1);
    issue({128'd0, {W{1'b1}}}, 128'd1, {W{1'b1}}, 128'd0, 1'b0);
    issue({128'd6, 128'd0}, {W{1'b1}}, 128'd6, 128'd6, 1'b0);
    drain();

    // Backpressure: result must hold for 20 cycles, then hand off.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(256'd1000, 128'd7, 128'd142, 128'd6, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 400);
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL bp_wait actual=out_valid_low required=out_valid_high");
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold", {out_valid, in_ready, quotient[7:0], remainder[7:0]},
          W'({1'b1, 1'b0, 8'd142, 8'd6}));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("handoff_out_valid", W'(out_valid), W'(0));
    chk("handoff_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    drain();

    // Reset mid-iteration discards the operation.
    issue(256'h3489BE8E_CB764171_00000000, 128'hFFFFFFFF, 128'h3489BE8F_00000000, 128'd0, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_quotient", quotient, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(256'h1_087DC432, 128'd3, 128'h5829EC10, 128'd2, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
